ieee32_to_ieee16_seq: RTL

Sequential converter that narrows a packed vector of NODES IEEE-754 binary32 values to binary16. It converts one element per clock under a start/busy/done handshake. It is the reverse of the fp16-to-fp32 widening stage that feeds the ANN. It packs fp32 results (e.g. ANN outputs or retrained weights) back into the fp16 format used by the convolution datapath.

---
 rtl/ieee32_to_ieee16_seq_pkg.sv | 21 ++
 rtl/ieee32_to_ieee16_seq_elem.sv | 61 ++++++
 rtl/ieee32_to_ieee16_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/ieee32_to_ieee16_seq_pkg.sv
// Shared constants and FSM encoding for the fp32 -> fp16 narrowing stage.
package ieee32_to_ieee16_seq_pkg;

  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam int          FP32_EXP_BIAS = 127;
  localparam int          FP16_EXP_BIAS = 15;

  // Biased fp32 exponent boundaries between the output classes.
  localparam logic [7:0] E32_NORM_MAX = 8'(FP32_EXP_BIAS + FP16_EXP_BIAS); // e = 15
  localparam logic [7:0] E32_NORM_MIN = 8'(FP32_EXP_BIAS - 14);            // e = -14
  localparam logic [7:0] E32_SUB_MIN  = 8'(FP32_EXP_BIAS - 25);            // e = -25
  localparam logic [7:0] E32_REBIAS   = 8'(FP32_EXP_BIAS - FP16_EXP_BIAS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ieee32_to_ieee16_seq_elem.sv
// Combinational binary32 -> binary16 narrowing of one element, RNE rounding.
module fp32_to_fp16_elem
  import ieee32_to_ieee16_seq_pkg::*;
(
  input  logic [31:0] f32_i,
  output logic [15:0] f16_o,
  output logic        ovf_o
);

  logic        s;
  logic [7:0]  ex;
  logic [22:0] man;
  logic        rnd;
  logic [4:0]  exp16;
  logic [14:0] nsum;
  logic [7:0]  sh;
  logic [34:0] wide;

  assign s   = f32_i[31];
  assign ex  = f32_i[30:23];
  assign man = f32_i[22:0];

  // Classify the input and produce the rounded fp16 pattern.
  always_comb begin
    f16_o = {s, 15'h0};
    ovf_o = 1'b0;
    rnd   = 1'b0;
    exp16 = '0;
    nsum  = '0;
    sh    = '0;
    wide  = '0;
    if (ex == 8'hFF) begin
      f16_o = (man != '0) ? {s, FP16_QNAN[14:0]} : {s, FP16_POS_INF[14:0]};
    end else if (ex == 8'h00) begin
      f16_o = {s, 15'h0};
    end else if (ex > E32_NORM_MAX) begin
      f16_o = {s, FP16_POS_INF[14:0]};
      ovf_o = 1'b1;
    end else if (ex >= E32_NORM_MIN) begin
      // Mantissa carry ripples into the exponent; exponent 31 means inf.
      exp16 = 5'(ex - E32_REBIAS);
      rnd   = man[12] & ((|man[11:0]) | man[13]);
      nsum  = {exp16, man[22:13]} + 15'(rnd);
      if (nsum[14:10] == 5'h1F) begin
        f16_o = {s, FP16_POS_INF[14:0]};
        ovf_o = 1'b1;
      end else begin
        f16_o = {s, nsum};
      end
    end else if (ex >= E32_SUB_MIN) begin
      // Shift 0..10 keeps everything shifted out inside the zero pad,
      // so the sticky bit only needs the low 24 bits.
      sh    = E32_NORM_MIN - 8'd1 - ex;
      wide  = {1'b1, man, 11'b0} >> sh;
      rnd   = wide[24] & ((|wide[23:0]) | wide[25]);
      // A round-up from 0x3FF lands naturally on the smallest normal.
      f16_o = {s, 15'({5'b0, wide[34:25]}) + 15'(rnd)};
    end
  end

endmodule

// File: rtl/ieee32_to_ieee16_seq.sv
// Sequential fp32 -> fp16 vector narrowing, one element per clock.
module ieee32_to_ieee16_seq
  import ieee32_to_ieee16_seq_pkg::*;
#(
  parameter int NODES        = 288,
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NODES*DATA_WIDTH_2-1:0]  input_fc,
  output logic [NODES*DATA_WIDTH_1-1:0]  output_fc,
  output logic                           busy,
  output logic                           done,
  output logic                           ovf
);

  localparam int             IW       = (NODES > 1) ? $clog2(NODES) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NODES - 1);

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q;
  logic [NODES*DATA_WIDTH_2-1:0]   buf_q;
  logic [NODES*DATA_WIDTH_1-1:0]   out_q;
  logic                            ovf_q;
  logic [DATA_WIDTH_2-1:0]         cur_f32;
  logic [DATA_WIDTH_1-1:0]         cur_f16;
  logic                            cur_ovf;

  assign cur_f32 = buf_q[int'(idx_q)*DATA_WIDTH_2 +: DATA_WIDTH_2];

  fp32_to_fp16_elem u_elem (
    .f32_i (cur_f32),
    .f16_o (cur_f16),
    .ovf_o (cur_ovf)
  );

  // Next state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Capture on start, then write one converted element per BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      buf_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      buf_q <= input_fc;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      out_q[int'(idx_q)*DATA_WIDTH_1 +: DATA_WIDTH_1] <= cur_f16;
      idx_q <= idx_q + IW'(1);
      ovf_q <= ovf_q | cur_ovf;
    end
  end

  assign output_fc = out_q;
  assign ovf       = ovf_q;

endmodule
